// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_FILL,
    ST_DONE
  } state_e;

  localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/imem_loader_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is combinational
// on the 4th byte so the loader can register the memory write on the same edge.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (in_valid) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {in_byte, sr_q[23:8]};
    end
  end

  assign word_valid = in_valid & (cnt_q == 2'd3);
  assign word       = {in_byte, sr_q};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for instr_mem: writes the program, pads with NOPs up to
// DEPTH and holds the core in reset until a load completes cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h00000000,
  parameter logic [31:0] NOP_WORD  = RV_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

  localparam int unsigned IW = $clog2(DEPTH) + 1;

  state_e        state_q;
  logic [IW-1:0] word_idx_q;
  logic [15:0]   len_q;
  logic [7:0]    len_lo_q;
  logic          len_byte_q;
  logic          s_ready_q, mem_we_q, busy_q, done_q, error_q, loaded_q, cpu_rst_n_q;
  logic [31:0]   mem_waddr_q, mem_wdata_q;

  logic [IW-1:0] widx_d;
  logic [31:0]   waddr_d;
  logic [16:0]   len_d;
  logic          byte_acc, last_data, at_depth;
  logic          pk_valid;
  logic [31:0]   pk_word;

  always_comb begin
    byte_acc  = s_valid & s_ready_q;
    widx_d    = word_idx_q + IW'(1);
    waddr_d   = BASE_ADDR + (32'(word_idx_q) << 2);
    len_d     = {1'b0, s_data, len_lo_q};
    last_data = (17'(widx_d) == {1'b0, len_q});
    at_depth  = (widx_d == IW'(DEPTH));
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_q == ST_IDLE),
    .in_valid   (byte_acc && (state_q == ST_DATA)),
    .in_byte    (s_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // cpu_rst_n tracks loaded & ~busy one cycle late: it is set only on leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      len_q       <= '0;
      len_lo_q    <= '0;
      len_byte_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= BASE_ADDR;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      loaded_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_LEN;
            error_q     <= 1'b0;
            loaded_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            s_ready_q   <= 1'b1;
            word_idx_q  <= '0;
            len_byte_q  <= 1'b0;
          end
        end
        ST_LEN: begin
          if (byte_acc) begin
            if (!len_byte_q) begin
              len_lo_q   <= s_data;
              len_byte_q <= 1'b1;
            end else begin
              len_q <= len_d[15:0];
              if (len_d > 17'(DEPTH)) begin
                error_q   <= 1'b1;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                s_ready_q <= 1'b0;
                state_q   <= ST_IDLE;
              end else if (len_d == '0) begin
                s_ready_q <= 1'b0;
                state_q   <= ST_FILL;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (pk_valid) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= pk_word;
            mem_waddr_q <= waddr_d;
            word_idx_q  <= widx_d;
            if (last_data) begin
              s_ready_q <= 1'b0;
              if (at_depth) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_FILL;
              end
            end
          end
        end
        ST_FILL: begin
          mem_we_q    <= 1'b1;
          mem_wdata_q <= NOP_WORD;
          mem_waddr_q <= waddr_d;
          word_idx_q  <= widx_d;
          if (at_depth) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          loaded_q    <= 1'b1;
          cpu_rst_n_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are driven and
// compared as the write port fires.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_we, busy, done, error, cpu_rst_n;
  logic [31:0] mem_waddr, mem_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_count = 0;
  logic [63:0] sb[$];
  logic [31:0] prog[64];

  imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      logic [63:0] e;
      wr_count++;
      chk("sb_avail", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("waddr", 64'(mem_waddr), 64'(e[63:32]));
        chk("wdata", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gmax);
    int unsigned gap;
    int unsigned n;
    logic acc;
    gap = (gmax == 0) ? 0 : $urandom_range(0, gmax);
    n = 0;
    acc = 1'b0;
    repeat (gap) cyc();
    s_valid = 1'b1;
    s_data  = b;
    do begin
      acc = s_ready;
      cyc();
      n++;
    end while (!acc && n < 200);
    s_valid = 1'b0;
    chk("byte_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  // Assumes start has already been pulsed.
  task automatic do_load(input logic [15:0] len, input int unsigned nw, input int unsigned gmax,
                         input logic exp_err, input logic hold_valid);
    int unsigned w0;
    w0 = wr_count;
    send_byte(len[7:0], gmax);
    send_byte(len[15:8], gmax);
    for (int unsigned i = 0; i < nw; i++) begin
      sb.push_back({32'(4 * i), prog[i]});
      for (int unsigned b = 0; b < 4; b++) send_byte(prog[i][8*b +: 8], gmax);
    end
    if (!exp_err)
      for (int unsigned i = nw; i < 64; i++) sb.push_back({32'(4 * i), NOP});
    if (hold_valid) begin
      s_valid = 1'b1;
      s_data  = 8'hFF;
      cyc();
      chk("fill_no_ready", 64'(s_ready), 64'd0);
    end
    wait_done();
    s_valid = 1'b0;
    chk("end_error", 64'(error), 64'(exp_err));
    chk("end_busy", 64'(busy), 64'd0);
    chk("cpu_rst_at_done", 64'(cpu_rst_n), 64'd0);
    cyc();
    chk("done_pulse", 64'(done), 64'd0);
    chk("cpu_rst_after", 64'(cpu_rst_n), 64'(!exp_err));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("write_count", 64'(wr_count - w0), exp_err ? 64'd0 : 64'd64);
  endtask

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00A00113;
    for (int unsigned i = 2; i < 64; i++) prog[i] = $urandom;

    // Reset values
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("idle_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

    // Two-word program, no gaps
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_s_ready", 64'(s_ready), 64'd1);
    do_load(16'd2, 2, 0, 1'b0, 1'b0);

    // Same stream with random valid gaps
    pulse_start();
    chk("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    do_load(16'd2, 2, 3, 1'b0, 1'b0);

    // Oversize length
    pulse_start();
    do_load(16'd65, 0, 0, 1'b1, 1'b0);
    cyc();
    chk("error_sticky", 64'(error), 64'd1);

    // Next start clears error; zero length fills the whole memory with NOPs
    pulse_start();
    chk("error_cleared", 64'(error), 64'd0);
    do_load(16'd0, 0, 0, 1'b0, 1'b1);

    // Full-depth program, no fill writes
    pulse_start();
    do_load(16'd64, 64, 1, 1'b0, 1'b0);

    // Start ignored mid-DATA, then reset after the 2nd word
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    sb.push_back({32'h0, prog[0]});
    for (int unsigned b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8], 0);
    pulse_start();
    chk("start_ignored_busy", 64'(busy), 64'd1);
    sb.push_back({32'h4, prog[1]});
    for (int unsigned b = 0; b < 4; b++) send_byte(prog[1][8*b +: 8], 0);
    repeat (2) cyc();
    chk("mid_sb_drained", 64'(sb.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_waddr", 64'(mem_waddr), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse_start();
    do_load(16'd2, 2, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
